// File: rtl/dly_update_sched_if.sv
// Request/commit bundle for dly_update_sched.
// master = stimulus side, slave = scheduler.
interface dly_update_sched_if #(
  parameter int WIDTH   = 32,
  parameter int DELAY_W = 8,
  parameter int NSLOTS  = 4
);
  localparam int CW = $clog2(NSLOTS) + 1;

  logic               req_valid;
  logic               req_ready;
  logic [WIDTH-1:0]   req_data;
  logic [DELAY_W-1:0] req_delay;
  logic [WIDTH-1:0]   out_data;
  logic               out_update;
  logic [CW-1:0]      pending_cnt;
  logic               drop_err;

  modport master (
    output req_valid, req_data, req_delay,
    input  req_ready, out_data, out_update, pending_cnt, drop_err
  );

  modport slave (
    input  req_valid, req_data, req_delay,
    output req_ready, out_data, out_update, pending_cnt, drop_err
  );
endinterface

// File: rtl/dly_update_sched.sv
// Cycle-based scheduler committing delayed writes to one target register.
// Define DLY_UPDATE_SCHED_INERTIAL_EN for inertial (cancel-on-new-request) mode.
module dly_update_sched #(
  parameter int               WIDTH     = 32,
  parameter int               DELAY_W   = 8,
  parameter int               NSLOTS    = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  dly_update_sched_if.slave bus
);
  localparam int IW = $clog2(NSLOTS);
  localparam int CW = IW + 1;

  logic [NSLOTS-1:0]  valid_q, valid_d;
  logic [DELAY_W-1:0] count_q [NSLOTS];
  logic [DELAY_W-1:0] count_d [NSLOTS];
  // older_q[i][j] is set when slot i was accepted before slot j.
  logic [NSLOTS-1:0]  older_q [NSLOTS];
  logic [NSLOTS-1:0]  older_d [NSLOTS];
  logic [WIDTH-1:0]   data_q  [NSLOTS];

  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_update_q, out_update_d;
  logic [CW-1:0]      pending_cnt_q, pending_cnt_d;
  logic               drop_err_q, drop_err_d;
  logic               req_ready_q, req_ready_d;

  logic [NSLOTS-1:0]  fire;
  logic [NSLOTS-1:0]  young;
  logic               accept;
  logic               have_free;
  logic [IW-1:0]      load_idx;
  logic [WIDTH-1:0]   win_data;

  assign accept = bus.req_valid && req_ready_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    fire  = '0;
    young = '0;
    for (int i = 0; i < NSLOTS; i++) begin
      fire[i] = valid_q[i] && (count_q[i] == '0);
    end
    // A firing slot wins only if no other firing slot is younger.
    for (int i = 0; i < NSLOTS; i++) begin
      young[i] = fire[i];
      for (int j = 0; j < NSLOTS; j++) begin
        if (j != i && fire[j] && !older_q[j][i]) young[i] = 1'b0;
      end
    end
    win_data = out_data_q;
    for (int i = 0; i < NSLOTS; i++) begin
      if (young[i]) win_data = data_q[i];
    end
  end

  always_comb begin
    valid_d   = valid_q;
    count_d   = count_q;
    older_d   = older_q;
    have_free = 1'b0;
    load_idx  = '0;

    for (int i = 0; i < NSLOTS; i++) begin
      if (fire[i]) begin
        valid_d[i] = 1'b0;
      end else if (valid_q[i]) begin
        count_d[i] = count_q[i] - DELAY_W'(1);
      end
    end

`ifdef DLY_UPDATE_SCHED_INERTIAL_EN
    // Every accepted request cancels all pending ones, so slot 0 is always used.
    have_free = 1'b1;
    if (accept) valid_d = '0;
`else
    // Slots freed on this edge are not offered until the next one.
    for (int i = NSLOTS - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        have_free = 1'b1;
        load_idx  = IW'(i);
      end
    end
`endif

    if (accept && have_free) begin
      valid_d[load_idx] = 1'b1;
      count_d[load_idx] = bus.req_delay;
      for (int j = 0; j < NSLOTS; j++) older_d[j][load_idx] = 1'b1;
      older_d[load_idx] = '0;
    end
  end

  always_comb begin
    out_data_d   = (|fire) ? win_data : out_data_q;
    out_update_d = |fire;
    drop_err_d   = drop_err_q | (bus.req_valid & ~req_ready_q);
    pending_cnt_d = '0;
    for (int i = 0; i < NSLOTS; i++) begin
      if (valid_d[i]) pending_cnt_d = pending_cnt_d + CW'(1);
    end
`ifdef DLY_UPDATE_SCHED_INERTIAL_EN
    req_ready_d = 1'b1;
`else
    req_ready_d = ~(&valid_d);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= '0;
      out_data_q    <= RESET_VAL;
      out_update_q  <= 1'b0;
      pending_cnt_q <= '0;
      drop_err_q    <= 1'b0;
      req_ready_q   <= 1'b1;
      for (int i = 0; i < NSLOTS; i++) begin
        count_q[i] <= '0;
        older_q[i] <= '0;
      end
    end else begin
      valid_q       <= valid_d;
      count_q       <= count_d;
      older_q       <= older_d;
      out_data_q    <= out_data_d;
      out_update_q  <= out_update_d;
      pending_cnt_q <= pending_cnt_d;
      drop_err_q    <= drop_err_d;
      req_ready_q   <= req_ready_d;
    end
  end

  // NOTE: payload storage is not reset; a slot's data is only read while valid_q marks it occupied.
  always_ff @(posedge clk) begin
    if (accept && have_free) data_q[load_idx] <= bus.req_data;
  end

  assign bus.out_data    = out_data_q;
  assign bus.out_update  = out_update_q;
  assign bus.pending_cnt = pending_cnt_q;
  assign bus.drop_err    = drop_err_q;
  assign bus.req_ready   = req_ready_q;
endmodule
